alu_exec: RTL
=============

# alu_exec

Execution-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU control decoder and carries out the operation on two register operands. ADD and SUB complete in one cycle. MUL runs on an iterative shift-add multiplier over WIDTH cycles. Input and output both use valid/ready handshakes, so the pipeline stalls on `in_ready` while a multiply is in flight.

## Interface
- `WIDTH`, 32: operand and result width.
- `TAG_W`, 5: width of the destination-register tag passed through with each operation.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high. Highest priority.
- `flush` input 1: synchronous abort. Drops the in-flight operation and any held result. Lower priority than `reset`.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: the block accepts the operation this cycle.
- `alu_control` input 4: opcode from the ALU control decoder.
- `src_a` input WIDTH: operand A.
- `src_b` input WIDTH: operand B.
- `tag_in` input TAG_W: destination tag.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: consumer takes the result.
- `result` output WIDTH: operation result.
- `tag_out` output TAG_W: tag of the result.
- `zero` output 1: `result == 0`.
- `overflow` output 1: signed overflow for ADD/SUB; 0 for MUL.
- `busy` output 1: high in state MUL.

## Operation
- Opcodes:
  - 4'b0000 ADD: `a+b`.
  - 4'b0001 SUB: `a-b`.
  - 4'b0010 MUL: low WIDTH bits of `a*b`, unsigned.
  - Any other code executes as ADD, matching the decoder's default.
- Arithmetic is modulo 2^WIDTH.
- Overflow rules:
  - ADD: `overflow = (a[MSB]==b[MSB]) && (r[MSB]!=a[MSB])`.
  - SUB: `overflow = (a[MSB]!=b[MSB]) && (r[MSB]!=a[MSB])`.
- Ready rule: `in_ready = (state==IDLE) && (!out_valid || out_ready)`.
- Acceptance occurs when `in_valid && in_ready`.
- States and transitions:
  - IDLE, accept ADD/SUB/other: `result`, flags and `tag_out` are registered and `out_valid` is set; stay in IDLE.
  - IDLE, accept MUL: load the multiplicand, the multiplier, a zeroed accumulator, `count = WIDTH-1` and the tag; go to MUL.
  - MUL: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator. Then shift the multiplicand left and the multiplier right, and decrement `count`.
  - MUL with `count==0`: write the final accumulator to `result`, set `out_valid`, clear `overflow`, return to IDLE.
- Output hold: while `out_valid && !out_ready`, `result`, `tag_out`, `zero` and `overflow` remain stable.
- `out_valid` clears on `out_ready` unless a new ALU result is being registered in the same cycle.
- Simultaneous events:
  - `out_valid && out_ready && in_valid` in IDLE: the old result is consumed and the new operation is accepted in the same cycle.
  - `flush` together with `in_valid`: nothing is accepted.
  - `reset` together with `flush`: reset wins (same end state).
- `flush` or `reset` during MUL: the multiply is discarded, state goes to IDLE, and no result is emitted.

## Timing
- Reset values: state IDLE, `out_valid=0`, `result=0`, `tag_out=0`, `zero=1`, `overflow=0`, `busy=0`, `in_ready=1` (since `out_valid=0`).
- ADD/SUB latency: accepted in cycle T, `out_valid` high in T+1.
- MUL latency: accepted in cycle T, `busy` high in T+1..T+WIDTH, `out_valid` high in T+WIDTH+1. For WIDTH=32 that is 33 cycles.
- Throughput:
  - ADD/SUB: one per cycle when `out_ready` is held high.
  - MUL: one per WIDTH+1 cycles.
- `in_ready` is combinational from state, `out_valid` and `out_ready`.
- There is no combinational path from `in_valid` to any output.

## Structure
- Package `alu_pkg` holds:
  - Opcode constants `ALU_ADD`, `ALU_SUB`, `ALU_MUL` (4 bits), shared with the ALU control decoder.
  - State typedef `alu_state_t` {IDLE, MUL}.
- Sub-module `mul_iter`, the iterative shift-add multiplier:
  - Ports: `start`, operands, `abort`, `done`, `product`.
  - It owns the counter and the shift registers.
  - `alu_exec` owns the handshake, the ADD/SUB datapath and the output registers.

## Test plan
- Reset then ADD, a=5, b=7 -> `out_valid` in T+1, result=12, zero=0, overflow=0.
- SUB, a=32'h8000_0000, b=1 -> result=32'h7FFF_FFFF, overflow=1. SUB, a=3, b=3 -> result=0, zero=1.
- MUL, a=32'hFFFF_FFFF, b=3 -> `busy` for 32 cycles, `in_ready=0` throughout, `out_valid` in T+33, result=32'hFFFF_FFFD, overflow=0.
- Back-to-back ADD stream with `out_ready` held low for 3 cycles:
  - `in_ready=0` and `result` held stable while stalled.
  - On release, the consumed result and the next accepted op occur in the same cycle, with no lost or duplicated tags.
- `flush` in the 10th MUL cycle -> state IDLE next cycle, `out_valid` never rises, next ADD 1+1 returns 2. Repeat with `reset` instead: all outputs at reset values.
- Opcode 4'b1111, a=2, b=2 -> result=4, matching ADD.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the execution-stage ALU.
package alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;

   typedef enum logic {IDLE, MUL} alu_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] mcand, mplr, acc, step_sum;
   logic [CW-1:0]    count;
   logic             active;

   // product includes the final step so the result can be registered on the last cycle
   assign step_sum = acc + (mplr[0] ? mcand : '0);
   assign product  = step_sum;
   assign done     = active && (count == '0);

   always_ff @(posedge clk) begin
      if (reset || abort) begin
         active <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplr   <= '0;
         acc    <= '0;
      end else if (start) begin
         active <= 1'b1;
         count  <= CW'(WIDTH-1);
         mcand  <= a;
         mplr   <= b;
         acc    <= '0;
      end else if (active) begin
         acc   <= step_sum;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         count <= count - CW'(1);
         if (count == '0)
            active <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU: single-cycle ADD/SUB, iterative MUL, valid/ready on both sides.
module alu_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [TAG_W-1:0] tag_out,
   output logic             zero,
   output logic             overflow,
   output logic             busy
);

   localparam int MSB = WIDTH - 1;

   alu_state_t       state, state_nx;
   logic             accept, is_mul, is_sub, alu_ovf, mul_done;
   logic [WIDTH-1:0] alu_res, mul_prod;
   logic [TAG_W-1:0] mul_tag;

   assign in_ready = (state == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready && !flush;
   assign is_mul   = (alu_control == ALU_MUL);
   assign is_sub   = (alu_control == ALU_SUB);
   assign busy     = (state == MUL);

   // unknown opcodes fall through to ADD
   always_comb begin
      alu_res = is_sub ? (src_a - src_b) : (src_a + src_b);
      if (is_sub)
         alu_ovf = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      else
         alu_ovf = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
   end

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (accept && is_mul),
      .abort   (flush),
      .a       (src_a),
      .b       (src_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept && is_mul) state_nx = MUL;
         MUL:  if (mul_done)         state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   // accept is only possible when the held result is free, so outputs stay stable under stall
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         tag_out   <= '0;
         zero      <= 1'b1;
         overflow  <= 1'b0;
         mul_tag   <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else begin
         if (out_ready)
            out_valid <= 1'b0;
         if (accept && !is_mul) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            tag_out   <= tag_in;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
         end else if (state == MUL && mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_prod;
            tag_out   <= mul_tag;
            zero      <= (mul_prod == '0);
            overflow  <= 1'b0;
         end
         if (accept && is_mul)
            mul_tag <= tag_in;
      end
   end

endmodule
